// File: rtl/scan_decoder.sv
// scan_decoder: registered SEL_W-to-2^SEL_W one-hot decoder.
//   DIRECT mode latches sel on a load strobe.
//   SCAN mode cycles through all outputs, holding each for a programmable dwell time.
//   Optional blank cycle between scan outputs: define SCAN_DECODER_BLANK_EN.
// All outputs are registered. Reset is asynchronous and active-low.
module scan_decoder #(
  parameter int SEL_W      = 3,
  parameter int DWELL_W    = 8,
  parameter int ACTIVE_LOW = 0,
  localparam int N         = 1 << SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N-1:0]       dout,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  localparam logic [N-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

  // One-hot decode of an index, with the output polarity applied.
  function automatic logic [N-1:0] decode(input logic [SEL_W-1:0] i);
    logic [N-1:0] oh;
    oh = {{(N-1){1'b0}}, 1'b1} << i;
    if (ACTIVE_LOW != 0) begin
      return ~oh;
    end else begin
      return oh;
    end
  endfunction

  state_t             state_r, state_s;
  logic [SEL_W-1:0]   idx_r, idx_s, idx_inc_s;
  logic [N-1:0]       dout_r, dout_s;
  logic               wrap_r, wrap_s;
  logic               busy_r, busy_s;
  logic [DWELL_W-1:0] dwell_reg_r, dwell_reg_s;
  logic [DWELL_W-1:0] dwell_cnt_r, dwell_cnt_s;
  logic               enter_scan_s;
`ifdef SCAN_DECODER_BLANK_EN
  logic               blank_r, blank_s;
`endif

  assign idx_inc_s = idx_r + SEL_W'(1'b1);

  // Next-state and next-output logic for the IDLE/DIRECT/SCAN machine.
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    dout_s       = INACTIVE;
    wrap_s       = 1'b0;
    dwell_reg_s  = dwell_reg_r;
    dwell_cnt_s  = dwell_cnt_r;
    enter_scan_s = 1'b0;
`ifdef SCAN_DECODER_BLANK_EN
    blank_s      = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (ena && !mode) begin
          state_s = ST_DIRECT;
          dout_s  = decode(idx_r);
        end else if (ena && mode) begin
          enter_scan_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DIRECT: begin
        if (!ena) begin
          state_s = ST_IDLE;
        end else if (mode) begin
          enter_scan_s = 1'b1;
        end else if (load) begin
          idx_s  = sel;
          dout_s = decode(sel);
        end else begin
          dout_s = decode(idx_r);
        end
      end
      ST_SCAN: begin
        if (!ena) begin
          state_s = ST_IDLE;
        end else if (!mode) begin
          state_s = ST_DIRECT;
          dout_s  = decode(idx_r);
        end else if (load) begin
          // A dwell reload takes priority over a pending advance.
          dwell_reg_s = dwell;
          dwell_cnt_s = dwell;
          dout_s      = decode(idx_r);
        end else if (dwell_cnt_r != {DWELL_W{1'b0}}) begin
          dwell_cnt_s = dwell_cnt_r - DWELL_W'(1'b1);
          dout_s      = decode(idx_r);
`ifdef SCAN_DECODER_BLANK_EN
        end else if (!blank_r) begin
          // Dwell expired: blank the outputs for one cycle before advancing.
          blank_s = 1'b1;
          dout_s  = INACTIVE;
`endif
        end else begin
          idx_s       = idx_inc_s;
          dout_s      = decode(idx_inc_s);
          dwell_cnt_s = dwell_reg_r;
          wrap_s      = (idx_inc_s == {SEL_W{1'b0}});
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    if (enter_scan_s) begin
      state_s     = ST_SCAN;
      idx_s       = {SEL_W{1'b0}};
      dout_s      = decode({SEL_W{1'b0}});
      dwell_reg_s = dwell;
      dwell_cnt_s = dwell;
    end else begin
      dwell_cnt_s = dwell_cnt_s;
    end
    busy_s = (state_s == ST_SCAN);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      idx_r       <= {SEL_W{1'b0}};
      dout_r      <= INACTIVE;
      wrap_r      <= 1'b0;
      busy_r      <= 1'b0;
      dwell_reg_r <= {DWELL_W{1'b0}};
      dwell_cnt_r <= {DWELL_W{1'b0}};
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      dout_r      <= dout_s;
      wrap_r      <= wrap_s;
      busy_r      <= busy_s;
      dwell_reg_r <= dwell_reg_s;
      dwell_cnt_r <= dwell_cnt_s;
    end
  end

`ifdef SCAN_DECODER_BLANK_EN
  // Blank-cycle flag: set for the single cycle between dwell expiry and advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_r <= 1'b0;
    end else begin
      blank_r <= blank_s;
    end
  end
`endif

  assign dout = dout_r;
  assign idx  = idx_r;
  assign wrap = wrap_r;
  assign busy = busy_r;

endmodule
